// File: rtl/vgafb_scanout_pkg.sv
// Shared vgafb constants: timing-register width, RGB565 field layout, video output bundle.
// Purely declarative; no latency or flow control of its own.
package vgafb_scanout_pkg;

  localparam int TIMING_W = 11;
  localparam int PIX_W    = 16;
  localparam int CH_W     = 8;

  typedef logic [TIMING_W-1:0] timing_t;

  // RGB565 field positions: r = [15:11], g = [10:5], b = [4:0]
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic            hsync_n;
    logic            vsync_n;
    logic            blank;
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } video_t;

  localparam video_t VIDEO_IDLE = '{
    hsync_n: 1'b1,
    vsync_n: 1'b1,
    blank:   1'b1,
    r:       '0,
    g:       '0,
    b:       '0
  };

endpackage

// File: rtl/vgafb_scanout.sv
// VGA framebuffer scanout: raster counters, sync/blank generation, RGB565->RGB888 expansion.
// Latency: video outputs registered one pix_ce after the counter state; pixel_ack/frame_start combinational.
// Backpressure: pixel_ack pops only in active area on pix_ce; starvation gives black (sticky flag if VGAFB_SCANOUT_UNDERRUN_EN).
module vgafb_scanout
  import vgafb_scanout_pkg::*;
(
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [TIMING_W-1:0] hres,
  input  logic [TIMING_W-1:0] hsync_start,
  input  logic [TIMING_W-1:0] hsync_end,
  input  logic [TIMING_W-1:0] hscan,
  input  logic [TIMING_W-1:0] vres,
  input  logic [TIMING_W-1:0] vsync_start,
  input  logic [TIMING_W-1:0] vsync_end,
  input  logic [TIMING_W-1:0] vscan,
  input  logic                enable,
  input  logic                pix_ce,
  input  logic                pixel_valid,
  input  logic [PIX_W-1:0]    pixel,
  output logic                pixel_ack,
  output logic                vga_hsync_n,
  output logic                vga_vsync_n,
  output logic                vga_blank,
  output logic [CH_W-1:0]     vga_r,
  output logic [CH_W-1:0]     vga_g,
  output logic [CH_W-1:0]     vga_b,
  output logic                underrun,
  input  logic                underrun_clear,
  output logic                frame_start
);

  timing_t hcount;
  timing_t vcount;
  logic    active;
  logic    scan_ce;
  rgb565_t px;
  video_t  video_d;
  video_t  video_q;

  assign active      = (hcount < hres) && (vcount < vres);
  assign scan_ce     = enable & pix_ce & ~sys_rst;
  assign pixel_ack   = scan_ce & active & pixel_valid;
  assign frame_start = scan_ce & (hcount == '0) & (vcount == '0);
  assign px          = rgb565_t'(pixel);

  // >= compares let a shrunk hscan/vscan wrap immediately instead of running to 2047
  always_ff @(posedge sys_clk) begin
    if (sys_rst || !enable) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_ce) begin
      if (hcount >= hscan) begin
        hcount <= '0;
        vcount <= (vcount >= vscan) ? '0 : vcount + TIMING_W'(1);
      end else begin
        hcount <= hcount + TIMING_W'(1);
      end
    end
  end

  always_comb begin
    video_d         = VIDEO_IDLE;
    video_d.hsync_n = ~((hcount >= hsync_start) && (hcount < hsync_end));
    video_d.vsync_n = ~((vcount >= vsync_start) && (vcount < vsync_end));
    video_d.blank   = ~active;
    if (active && pixel_valid) begin
      video_d.r = {px.r, px.r[4:2]};
      video_d.g = {px.g, px.g[5:4]};
      video_d.b = {px.b, px.b[4:2]};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || !enable) begin
      video_q <= VIDEO_IDLE;
    end else if (pix_ce) begin
      video_q <= video_d;
    end
  end

  assign vga_hsync_n = video_q.hsync_n;
  assign vga_vsync_n = video_q.vsync_n;
  assign vga_blank   = video_q.blank;
  assign vga_r       = video_q.r;
  assign vga_g       = video_q.g;
  assign vga_b       = video_q.b;

`ifdef VGAFB_SCANOUT_UNDERRUN_EN
  logic underrun_q;

  // set wins over a simultaneous clear so no starvation event is lost
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= (scan_ce & active & ~pixel_valid) | (underrun_q & ~underrun_clear);
    end
  end

  assign underrun = underrun_q;
`else
  logic unused_clear;

  assign unused_clear = underrun_clear;
  assign underrun     = 1'b0;
`endif

endmodule

// File: tb/tb_vgafb_scanout.sv
// Directed bench for vgafb_scanout on a tiny 8x5 raster (4x2 active).
// Define VGAFB_SCANOUT_UNDERRUN_EN for both bench and RTL to exercise the sticky underrun flag.
module tb_vgafb_scanout;
  import vgafb_scanout_pkg::*;

  logic          sys_clk;
  logic          sys_rst;
  timing_t       hres, hsync_start, hsync_end, hscan;
  timing_t       vres, vsync_start, vsync_end, vscan;
  logic          enable, pix_ce, pixel_valid, pixel_ack;
  logic [15:0]   pixel;
  logic          vga_hsync_n, vga_vsync_n, vga_blank;
  logic [7:0]    vga_r, vga_g, vga_b;
  logic          underrun, underrun_clear, frame_start;

  int n_cmp = 0;
  int n_err = 0;
  int acks, fs_cnt, hs_lo, vs_lo, bl_lo;

`ifdef VGAFB_SCANOUT_UNDERRUN_EN
  localparam int UR = 1;
`else
  localparam int UR = 0;
`endif

  vgafb_scanout dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .hres           (hres),
    .hsync_start    (hsync_start),
    .hsync_end      (hsync_end),
    .hscan          (hscan),
    .vres           (vres),
    .vsync_start    (vsync_start),
    .vsync_end      (vsync_end),
    .vscan          (vscan),
    .enable         (enable),
    .pix_ce         (pix_ce),
    .pixel_valid    (pixel_valid),
    .pixel          (pixel),
    .pixel_ack      (pixel_ack),
    .vga_hsync_n    (vga_hsync_n),
    .vga_vsync_n    (vga_vsync_n),
    .vga_blank      (vga_blank),
    .vga_r          (vga_r),
    .vga_g          (vga_g),
    .vga_b          (vga_b),
    .underrun       (underrun),
    .underrun_clear (underrun_clear),
    .frame_start    (frame_start)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic clr_counts();
    acks = 0; fs_cnt = 0; hs_lo = 0; vs_lo = 0; bl_lo = 0;
  endtask

  task automatic count_regs();
    hs_lo += int'(!vga_hsync_n);
    vs_lo += int'(!vga_vsync_n);
    bl_lo += int'(!vga_blank);
  endtask

  initial begin
    hres = 11'd4; hsync_start = 11'd5; hsync_end = 11'd6; hscan = 11'd7;
    vres = 11'd2; vsync_start = 11'd3; vsync_end = 11'd4; vscan = 11'd4;
    sys_rst = 1'b1; enable = 1'b1; pix_ce = 1'b1; pixel_valid = 1'b1;
    pixel = 16'h1234; underrun_clear = 1'b0;

    // reset held with enable/pix_ce/valid high: no ack, idle outputs
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_hsync", 32'(vga_hsync_n), 1);
    chk("rst_vsync", 32'(vga_vsync_n), 1);
    chk("rst_blank", 32'(vga_blank), 1);
    chk("rst_rgb", {8'h0, vga_r, vga_g, vga_b}, 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_ack", 32'(pixel_ack), 0);
    chk("rst_fs", 32'(frame_start), 0);
    @(posedge sys_clk); #1;

    // frame 1: full frame at pix_ce=1, pixel 0x1234 -> r 0x10 g 0x45 b 0xA5
    clr_counts();
    for (int n = 0; n < 40; n++) begin
      sys_rst = 1'b0; pix_ce = 1'b1; pixel_valid = 1'b1; pixel = 16'h1234;
      #1;
      acks += int'(pixel_ack); fs_cnt += int'(frame_start);
      if (n == 0) chk("a_fs_first", 32'(frame_start), 1);
      @(posedge sys_clk); #1;
      count_regs();
      if (n == 0) chk("a_rgb_1234", {8'h0, vga_r, vga_g, vga_b}, 'h1045A5);
      if (n == 4) begin
        chk("a_blank_h4", 32'(vga_blank), 1);
        chk("a_r_h4", 32'(vga_r), 0);
      end
    end
    chk("a_acks", 32'(acks), 8);
    chk("a_fs_cnt", 32'(fs_cnt), 1);
    chk("a_hsync_lo", 32'(hs_lo), 5);
    chk("a_vsync_lo", 32'(vs_lo), 8);
    chk("a_blank_lo", 32'(bl_lo), 8);

    // frame 2: colour, starvation at (2,0), clear, simultaneous set+clear at (0,1)
    for (int n = 0; n < 40; n++) begin
      pixel = 16'hF81F;
      pixel_valid = !(n == 2 || n == 8);
      underrun_clear = (n == 4 || n == 8);
      #1;
      if (n == 0) chk("b_fs_period40", 32'(frame_start), 1);
      if (n == 2) chk("b_starve_ack", 32'(pixel_ack), 0);
      @(posedge sys_clk); #1;
      if (n == 0) chk("b_rgb_f81f", {8'h0, vga_r, vga_g, vga_b}, 'hFF00FF);
      if (n == 2) begin
        chk("b_starve_rgb", {8'h0, vga_r, vga_g, vga_b}, 0);
        chk("b_starve_blank", 32'(vga_blank), 0);
        chk("b_underrun_set", 32'(underrun), UR);
      end
      if (n == 3) chk("b_underrun_sticky", 32'(underrun), UR);
      if (n == 4) chk("b_underrun_clr", 32'(underrun), 0);
      if (n == 8) chk("b_underrun_setclr", 32'(underrun), UR);
    end
    underrun_clear = 1'b0; pixel_valid = 1'b1;

    // frame 3: pix_ce every second cycle -> 80-cycle frame, held outputs
    clr_counts();
    for (int m = 0; m < 80; m++) begin
      pix_ce = (m % 2 == 0); pixel = 16'hFFFF;
      #1;
      acks += int'(pixel_ack); fs_cnt += int'(frame_start);
      if (m == 0) chk("c_fs_first", 32'(frame_start), 1);
      if (m == 1) chk("c_ack_noce", 32'(pixel_ack), 0);
      @(posedge sys_clk); #1;
      count_regs();
    end
    chk("c_acks", 32'(acks), 8);
    chk("c_fs_cnt", 32'(fs_cnt), 1);
    chk("c_hsync_lo", 32'(hs_lo), 10);
    chk("c_vsync_lo", 32'(vs_lo), 16);
    chk("c_blank_lo", 32'(bl_lo), 16);

    // frame 4: reset pulse at (3,1)
    for (int p = 0; p < 12; p++) begin
      pix_ce = 1'b1;
      sys_rst = (p == 11);
      #1;
      if (p == 0) chk("d_fs_period80", 32'(frame_start), 1);
      if (p == 11) chk("d_ack_in_rst", 32'(pixel_ack), 0);
      @(posedge sys_clk); #1;
    end
    chk("d_hsync", 32'(vga_hsync_n), 1);
    chk("d_vsync", 32'(vga_vsync_n), 1);
    chk("d_blank", 32'(vga_blank), 1);
    chk("d_rgb", {8'h0, vga_r, vga_g, vga_b}, 0);
    chk("d_underrun", 32'(underrun), 0);

    // after release: hscan shrinks 7->3 at hcount=6, then enable drop/raise
    clr_counts();
    for (int q = 0; q < 28; q++) begin
      sys_rst = 1'b0;
      hscan = (q >= 6 && q < 24) ? 11'd3 : 11'd7;
      enable = !(q == 25 || q == 26);
      #1;
      if (q <= 22) acks += int'(pixel_ack);
      if (q >= 1 && q <= 22) fs_cnt += int'(frame_start);
      if (q == 0) chk("e_fs_after_rst", 32'(frame_start), 1);
      if (q == 7) chk("e_ack_wrapped", 32'(pixel_ack), 1);
      if (q == 23) chk("e_fs_short", 32'(frame_start), 1);
      if (q == 26) begin
        chk("e_dis_ack", 32'(pixel_ack), 0);
        chk("e_dis_fs", 32'(frame_start), 0);
      end
      if (q == 27) begin
        chk("e_en_fs", 32'(frame_start), 1);
        chk("e_en_ack", 32'(pixel_ack), 1);
      end
      @(posedge sys_clk); #1;
      if (q == 7) chk("e_blank_wrapped", 32'(vga_blank), 0);
      if (q == 25) begin
        chk("e_dis_blank", 32'(vga_blank), 1);
        chk("e_dis_hsync", 32'(vga_hsync_n), 1);
        chk("e_dis_r", 32'(vga_r), 0);
      end
    end
    chk("e_acks", 32'(acks), 8);
    chk("e_fs_cnt", 32'(fs_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
